// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared types, constants and select encoding for the round-robin mux arbiter
package rr_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    // Requester index to {s0,s1}: a=00, b=01, c=10, d=11 (s0 is the MSB)
    function automatic logic [1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/mux4_datapath.sv
// rtl/mux4_datapath.sv - WIDTH-parametric 4:1 data mux driven by selects s0,s1
module mux4_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic [WIDTH-1:0] din_c,
    input  logic [WIDTH-1:0] din_d,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        case ({s0, s1})
            2'b00:   dout = din_a;
            2'b01:   dout = din_b;
            2'b10:   dout = din_c;
            default: dout = din_d;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter sequencing four requesters onto one valid/ready output
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   din_a,
    input  logic [WIDTH-1:0]   din_b,
    input  logic [WIDTH-1:0]   din_c,
    input  logic [WIDTH-1:0]   din_d,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   dout,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s0,
    output logic               s1
);

    localparam int                CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_HOLD - 1);

    state_t               state, state_d;
    logic [NUM_REQ-1:0]   gnt_d;
    logic                 s0_d, s1_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     last, last_d;
    logic [IDX_W-1:0]     g_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 pick_found;
    logic                 xfer;

    // The registered selects double as the granted index
    assign g_idx     = {s0, s1};
    assign out_valid = (state == GRANT) && req[g_idx];
    assign xfer      = out_valid && out_ready;

    // Search starts just after the last released requester and wraps; i=NUM_REQ lands on last itself
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + IDX_W'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        {s0_d, s1_d} = {s0, s1};
        cnt_d      = cnt;
        last_d     = last;
        case (state)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    gnt_d        = NUM_REQ'(1) << pick_idx;
                    {s0_d, s1_d} = idx_to_sel(pick_idx);
                    cnt_d        = '0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                // Without a transfer the grant is held, so stalled data is never dropped
                if (!req[g_idx] || (xfer && cnt == LAST_BEAT)) begin
                    last_d  = g_idx;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
            cnt   <= '0;
            last  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            s0    <= s0_d;
            s1    <= s1_d;
            cnt   <= cnt_d;
            last  <= last_d;
        end
    end

    mux4_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .s0    (s0),
        .s1    (s1),
        .din_a (din_a),
        .din_b (din_b),
        .din_c (din_c),
        .din_d (din_d),
        .dout  (dout)
    );

endmodule
